matrix_scan_controller: RTL and testbench

Synchronous scan sequencer for the LED matrix display. It replaces the ripple-divided row and image selectors with single-clock, tick-enabled sequencing, and inserts a blanking interval between rows to prevent ghosting. Image changes come from a requester (irrigation status logic) through a req/ack handshake, or from an optional auto-rotate mode, and take effect only at frame boundaries. It sits between the system clock and the row decoder / image ROM address.

---
 rtl/matrix_scan_controller_if.sv | 23 ++
 rtl/matrix_scan_controller.sv | 157 +++++++++++++++
 tb/tb_matrix_scan_controller.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_scan_controller_if.sv
// Control, image-request and display-drive signals of the LED matrix scan sequencer.
interface matrix_scan_controller_if;
  logic       enable;
  logic       auto_rotate;
  logic       img_req;
  logic [2:0] img_id;
  logic       img_ack;
  logic [2:0] row_sel;
  logic [2:0] img_sel;
  logic       row_en;
  logic       blank;
  logic       frame_start;

  modport master (
    output enable, auto_rotate, img_req, img_id,
    input  img_ack, row_sel, img_sel, row_en, blank, frame_start
  );

  modport slave (
    input  enable, auto_rotate, img_req, img_id,
    output img_ack, row_sel, img_sel, row_en, blank, frame_start
  );
endinterface

// File: rtl/matrix_scan_controller.sv
// Tick-enabled row/blank scan sequencer for the LED matrix, with frame-aligned
// image selection from a req/ack requester or an auto-rotate schedule.
module matrix_scan_controller #(
  parameter int unsigned ROW_TICKS        = 1000,
  parameter int unsigned BLANK_TICKS      = 24,
  parameter int unsigned NUM_ROWS         = 7,
  parameter int unsigned NUM_IMAGES       = 8,
  parameter int unsigned FRAMES_PER_IMAGE = 32
) (
  input logic                     clock,
  input logic                     reset,
  matrix_scan_controller_if.slave bus
);

  localparam int unsigned MAX_TICKS = (ROW_TICKS > BLANK_TICKS) ? ROW_TICKS : BLANK_TICKS;
  localparam int unsigned CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam int unsigned FC_W      = (FRAMES_PER_IMAGE > 1) ? $clog2(FRAMES_PER_IMAGE) : 1;

  localparam logic [CNT_W-1:0] ROW_LOAD   = CNT_W'(ROW_TICKS - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_TICKS - 1);
  localparam logic [FC_W-1:0]  FC_LAST    = FC_W'(FRAMES_PER_IMAGE - 1);
  localparam logic [2:0]       ROW_LAST   = 3'(NUM_ROWS - 1);
  localparam logic [2:0]       IMG_LAST   = 3'(NUM_IMAGES - 1);
  localparam logic [3:0]       IMG_COUNT  = 4'(NUM_IMAGES);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [2:0]       row_sel_q, row_sel_d;
  logic [2:0]       img_sel_q, img_sel_d;
  logic             armed_q, armed_d;
  logic             img_ack_q, img_ack_d;
  logic             frame_start_q, frame_start_d;
  logic             row_en_q, row_en_d;
  logic             blank_q, blank_d;

  logic             boundary;
  logic             idle_update;
  logic             req_ok;
  logic             id_valid;

  // Sequencing and image selection for the next edge.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    frame_cnt_d   = frame_cnt_q;
    row_sel_d     = row_sel_q;
    img_sel_d     = img_sel_q;
    img_ack_d     = 1'b0;
    frame_start_d = 1'b0;
    boundary      = 1'b0;
    idle_update   = 1'b0;
    req_ok        = bus.img_req & armed_q;
    id_valid      = ({1'b0, bus.img_id} < IMG_COUNT);

    unique case (state_q)
      IDLE: begin
        idle_update = 1'b1;
        if (bus.enable) begin
          state_d       = BLANK;
          row_sel_d     = 3'd0;
          cnt_d         = BLANK_LOAD;
          frame_start_d = 1'b1;
        end
      end
      BLANK: begin
        if (!bus.enable) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = DRIVE;
          cnt_d   = ROW_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DRIVE: begin
        if (!bus.enable) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = BLANK;
          cnt_d   = BLANK_LOAD;
          if (row_sel_q == ROW_LAST) begin
            row_sel_d     = 3'd0;
            frame_start_d = 1'b1;
            boundary      = 1'b1;
          end else begin
            row_sel_d = row_sel_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A pending request beats auto-rotate; out-of-range ids are acked but ignored.
    if (idle_update || boundary) begin
      if (req_ok) begin
        img_ack_d = 1'b1;
        if (id_valid) begin
          img_sel_d   = bus.img_id;
          frame_cnt_d = '0;
        end
      end else if (boundary && bus.auto_rotate) begin
        if (frame_cnt_q == FC_LAST) begin
          img_sel_d   = (img_sel_q == IMG_LAST) ? 3'd0 : img_sel_q + 3'd1;
          frame_cnt_d = '0;
        end else begin
          frame_cnt_d = frame_cnt_q + FC_W'(1);
        end
      end
    end
    if (!bus.auto_rotate) begin
      frame_cnt_d = '0;
    end

    armed_d  = !bus.img_req ? 1'b1 : (img_ack_d ? 1'b0 : armed_q);
    row_en_d = (state_d == DRIVE);
    blank_d  = ~row_en_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      frame_cnt_q   <= '0;
      row_sel_q     <= 3'd0;
      img_sel_q     <= 3'd0;
      armed_q       <= 1'b1;
      img_ack_q     <= 1'b0;
      frame_start_q <= 1'b0;
      row_en_q      <= 1'b0;
      blank_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      row_sel_q     <= row_sel_d;
      img_sel_q     <= img_sel_d;
      armed_q       <= armed_d;
      img_ack_q     <= img_ack_d;
      frame_start_q <= frame_start_d;
      row_en_q      <= row_en_d;
      blank_q       <= blank_d;
    end
  end

  assign bus.img_ack     = img_ack_q;
  assign bus.row_sel     = row_sel_q;
  assign bus.img_sel     = img_sel_q;
  assign bus.row_en      = row_en_q;
  assign bus.blank       = blank_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Self-checking bench for matrix_scan_controller: directed scenarios plus
// randomized traffic compared against a time-indexed reference model.
module tb_matrix_scan_controller;

  localparam int unsigned ROW_TICKS        = 4;
  localparam int unsigned BLANK_TICKS      = 2;
  localparam int unsigned NUM_ROWS         = 3;
  localparam int unsigned NUM_IMAGES       = 5;
  localparam int unsigned FRAMES_PER_IMAGE = 2;
  localparam int ROWP  = BLANK_TICKS + ROW_TICKS;
  localparam int FRAME = NUM_ROWS * ROWP;
  localparam logic [9:0] RESET_VEC = 10'b01_000_000_00;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  matrix_scan_controller_if bus();

  matrix_scan_controller #(
    .ROW_TICKS(ROW_TICKS), .BLANK_TICKS(BLANK_TICKS), .NUM_ROWS(NUM_ROWS),
    .NUM_IMAGES(NUM_IMAGES), .FRAMES_PER_IMAGE(FRAMES_PER_IMAGE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: position in the scan is just the edge count since the scan started.
  typedef struct packed {
    bit scan; int k; int row; int img; int fcnt; bit armed; bit ack; bit fs; bit row_en;
  } model_t;

  function automatic model_t model_reset();
    model_t r;
    r = '0;
    r.armed = 1'b1;
    return r;
  endfunction

  function automatic model_t model_step(model_t m, logic en, logic ar, logic req, logic [2:0] id);
    model_t n;
    bit idle, bnd;
    n = m; n.ack = 1'b0; n.fs = 1'b0; idle = !m.scan; bnd = 1'b0;
    if (!m.scan) begin
      if (en) begin n.scan = 1'b1; n.k = 0; n.row = 0; n.fs = 1'b1; end
    end else if (!en) begin
      n.scan = 1'b0;
    end else begin
      n.k = m.k + 1;
      if (n.k % FRAME == 0) begin n.fs = 1'b1; bnd = 1'b1; end
      n.row = (n.k % FRAME) / ROWP;
    end
    if (idle || bnd) begin
      if (req && m.armed) begin
        n.ack = 1'b1;
        if (int'(id) < NUM_IMAGES) begin n.img = int'(id); n.fcnt = 0; end
      end else if (bnd && ar) begin
        if (m.fcnt + 1 == FRAMES_PER_IMAGE) begin n.img = (m.img + 1) % NUM_IMAGES; n.fcnt = 0; end
        else n.fcnt = m.fcnt + 1;
      end
    end
    if (!ar) n.fcnt = 0;
    n.armed  = !req ? 1'b1 : (n.ack ? 1'b0 : m.armed);
    n.row_en = n.scan && ((n.k % ROWP) >= BLANK_TICKS);
    return n;
  endfunction

  model_t m;
  always @(posedge clock or posedge reset) begin
    if (reset) m <= model_reset();
    else       m <= model_step(m, bus.enable, bus.auto_rotate, bus.img_req, bus.img_id);
  end

  logic [9:0] obs, exp_vec;
  assign obs = {bus.row_en, bus.blank, bus.row_sel, bus.img_sel, bus.img_ack, bus.frame_start};
  always_comb exp_vec = {m.row_en, ~m.row_en, 3'(m.row), 3'(m.img), m.ack, m.fs};

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.enable = 1'b0; bus.auto_rotate = 1'b0; bus.img_req = 1'b0; bus.img_id = 3'd0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.enable = 1'b0; bus.auto_rotate = 1'b0; bus.img_req = 1'b0; bus.img_id = 3'd0;
    @(negedge clock);
    checks++;
    if (obs !== RESET_VEC) begin errors++; $display("FAIL reset_values: got %b want %b", obs, RESET_VEC); end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== RESET_VEC) begin errors++; $display("FAIL reset_idle cyc %0d: got %b want %b", i, obs, RESET_VEC); end
    end
  endtask

  task automatic test_scan_timing();
    do_reset();
    bus.enable = 1'b1;
    for (int e = 0; e <= 40; e++) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin errors++; $display("FAIL scan_timing edge %0d: got %b want %b", e, obs, exp_vec); end
      if (e == 18) begin
        checks++;
        if (bus.frame_start !== 1'b1 || bus.row_en !== 1'b0)
          begin errors++; $display("FAIL scan_frame18: fs=%b row_en=%b want fs=1 row_en=0", bus.frame_start, bus.row_en); end
      end
      if (e == 12) begin
        checks++;
        if (bus.row_sel !== 3'd2) begin errors++; $display("FAIL scan_row12: got %0d want 2", bus.row_sel); end
      end
    end
  endtask

  task automatic test_idle_request();
    do_reset();
    bus.img_req = 1'b1; bus.img_id = 3'd3;
    tick();
    checks++;
    if (bus.img_ack !== 1'b1 || bus.img_sel !== 3'd3)
      begin errors++; $display("FAIL idle_req: ack=%b sel=%0d want ack=1 sel=3", bus.img_ack, bus.img_sel); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.img_ack !== 1'b0) begin errors++; $display("FAIL idle_held_req cyc %0d: ack=%b want 0", i, bus.img_ack); end
    end
    bus.img_req = 1'b0;
    tick();
    bus.img_req = 1'b1; bus.img_id = 3'd1;
    tick();
    checks++;
    if (bus.img_ack !== 1'b1 || bus.img_sel !== 3'd1)
      begin errors++; $display("FAIL idle_rereq: ack=%b sel=%0d want ack=1 sel=1", bus.img_ack, bus.img_sel); end
    bus.img_req = 1'b0;
    tick();
  endtask

  task automatic test_scan_request();
    do_reset();
    bus.enable = 1'b1;
    for (int e = 0; e <= 20; e++) begin
      tick();
      if (e == 6) begin bus.img_req = 1'b1; bus.img_id = 3'd2; end
      if (e > 6 && e < 18) begin
        checks++;
        if (bus.img_ack !== 1'b0 || bus.img_sel !== 3'd0)
          begin errors++; $display("FAIL scan_req_early edge %0d: ack=%b sel=%0d want 0/0", e, bus.img_ack, bus.img_sel); end
      end
      if (e == 18) begin
        checks++;
        if ({bus.img_ack, bus.img_sel, bus.frame_start, bus.row_en, bus.row_sel} !== {1'b1, 3'd2, 1'b1, 1'b0, 3'd0})
          begin errors++; $display("FAIL scan_req_boundary: ack=%b sel=%0d fs=%b ren=%b row=%0d want 1/2/1/0/0",
                 bus.img_ack, bus.img_sel, bus.frame_start, bus.row_en, bus.row_sel); end
        bus.img_req = 1'b0;
      end
    end
  endtask

  task automatic test_auto_rotate();
    do_reset();
    bus.auto_rotate = 1'b1; bus.enable = 1'b1;
    for (int e = 0; e <= 75; e++) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin errors++; $display("FAIL auto_rotate edge %0d: got %b want %b", e, obs, exp_vec); end
      if (e == 35 || e == 36 || e == 72) begin
        checks++;
        if (bus.img_sel !== ((e == 35) ? 3'd0 : (e == 36) ? 3'd1 : 3'd2))
          begin errors++; $display("FAIL auto_step edge %0d: got %0d", e, bus.img_sel); end
      end
    end
  endtask

  task automatic test_wrap_and_priority();
    do_reset();
    bus.img_req = 1'b1; bus.img_id = 3'd4;
    tick();
    bus.img_req = 1'b0;
    tick();
    checks++;
    if (bus.img_sel !== 3'd4) begin errors++; $display("FAIL wrap_setup: got %0d want 4", bus.img_sel); end
    bus.auto_rotate = 1'b1; bus.enable = 1'b1;
    for (int e = 0; e <= 108; e++) begin
      tick();
      if (e == 60) begin bus.img_req = 1'b1; bus.img_id = 3'd2; end
      if (e == 36) begin
        checks++;
        if (bus.img_sel !== 3'd0) begin errors++; $display("FAIL wrap_to_zero: got %0d want 0", bus.img_sel); end
      end
      if (e == 72) begin
        checks++;
        if (bus.img_sel !== 3'd2 || bus.img_ack !== 1'b1)
          begin errors++; $display("FAIL req_beats_rotate: sel=%0d ack=%b want 2/1", bus.img_sel, bus.img_ack); end
        bus.img_req = 1'b0;
      end
      if (e == 90) begin
        checks++;
        if (bus.img_sel !== 3'd2) begin errors++; $display("FAIL count_restart: got %0d want 2", bus.img_sel); end
      end
      if (e == 108) begin
        checks++;
        if (bus.img_sel !== 3'd3) begin errors++; $display("FAIL rotate_after_req: got %0d want 3", bus.img_sel); end
      end
    end
  endtask

  task automatic test_invalid_id();
    do_reset();
    bus.img_req = 1'b1; bus.img_id = 3'd3;
    tick();
    bus.img_req = 1'b0;
    tick();
    bus.img_req = 1'b1; bus.img_id = 3'd6;
    tick();
    checks++;
    if (bus.img_ack !== 1'b1 || bus.img_sel !== 3'd3)
      begin errors++; $display("FAIL invalid_id: ack=%b sel=%0d want ack=1 sel=3", bus.img_ack, bus.img_sel); end
    bus.img_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_row();
    do_reset();
    bus.img_req = 1'b1; bus.img_id = 3'd3;
    tick();
    bus.img_req = 1'b0; bus.enable = 1'b1;
    for (int e = 0; e <= 8; e++) tick();
    checks++;
    if (bus.row_en !== 1'b1 || bus.row_sel !== 3'd1 || bus.img_sel !== 3'd3)
      begin errors++; $display("FAIL mid_row_setup: ren=%b row=%0d sel=%0d want 1/1/3", bus.row_en, bus.row_sel, bus.img_sel); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs !== RESET_VEC) begin errors++; $display("FAIL async_reset: got %b want %b", obs, RESET_VEC); end
    @(negedge clock);
    reset = 1'b0;
    bus.enable = 1'b0;
  endtask

  task automatic test_enable_drop();
    do_reset();
    bus.enable = 1'b1;
    for (int e = 0; e <= 9; e++) tick();
    bus.enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({bus.row_en, bus.blank, bus.row_sel, bus.frame_start} !== {1'b0, 1'b1, 3'd1, 1'b0})
        begin errors++; $display("FAIL enable_drop cyc %0d: ren=%b blank=%b row=%0d fs=%b want 0/1/1/0",
               i, bus.row_en, bus.blank, bus.row_sel, bus.frame_start); end
    end
    bus.enable = 1'b1;
    tick();
    checks++;
    if (bus.frame_start !== 1'b1 || bus.row_sel !== 3'd0)
      begin errors++; $display("FAIL reenable: fs=%b row=%0d want 1/0", bus.frame_start, bus.row_sel); end
  endtask

  task automatic test_random();
    do_reset();
    bus.enable = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin errors++; $display("FAIL random cyc %0d: got %b want %b", c, obs, exp_vec); end
      bus.enable = ($urandom_range(0, 199) != 0) ? 1'b1 : (bus.enable ? 1'b0 : 1'b1);
      if ($urandom_range(0, 99) == 0) bus.auto_rotate = ~bus.auto_rotate;
      if (!bus.img_req) begin
        if ($urandom_range(0, 19) == 0) begin bus.img_req = 1'b1; bus.img_id = 3'($urandom_range(0, 7)); end
      end else if (!m.armed && $urandom_range(0, 1) == 0) begin
        bus.img_req = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_timing();
    test_idle_request();
    test_scan_request();
    test_auto_rotate();
    test_wrap_and_priority();
    test_invalid_id();
    test_reset_mid_row();
    test_enable_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
